quad_decoder: RTL and testbench

Quadrature encoder front end for the motor-control datapath. Synchronizes and glitch-filters the encoder A/B pins, decodes them 4x into a signed position count, direction, in-revolution index and per-window speed, and raises a one-cycle revolution interrupt. Its outputs feed the address-decode/bus block (`dir`, `spin`, `int3` source, readable position/speed) that sits beside the PWM counter in the top level.

---
 rtl/quad_decoder_if.sv | 24 ++
 rtl/quad_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_quad_decoder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// Pin and result bundle for the quadrature decoder. The decoder uses the slave
// modport; whatever drives the encoder pins and reads the results uses master.
interface quad_decoder_if;
  logic        a_in;
  logic        b_in;
  logic        clr;
  logic [15:0] pos;
  logic        dir;
  logic        spin;
  logic [15:0] speed;
  logic        speed_vld;
  logic        rev_int;
  logic        err;

  modport master (
    output a_in, b_in, clr,
    input  pos, dir, spin, speed, speed_vld, rev_int, err
  );

  modport slave (
    input  a_in, b_in, clr,
    output pos, dir, spin, speed, speed_vld, rev_int, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: pin sync, glitch filter, 4x decode into
// position, direction, revolution index, per-window speed and a revolution IRQ.
module quad_decoder #(
  parameter int unsigned FILT = 4,
  parameter int unsigned CPR  = 96,
  parameter int unsigned WIN  = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  quad_decoder_if.slave bus
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned IW = $clog2(FILT + 3);
  localparam int unsigned RW = $clog2(CPR);
  localparam int unsigned WW = $clog2(WIN);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      a_sync_q, b_sync_q;
  logic [1:0]      raw;
  logic [1:0]      filt_q, filt_d;
  logic [FW-1:0]   fcnt_q [2];
  logic [FW-1:0]   fcnt_d [2];
  logic [IW-1:0]   init_q, init_d;
  logic [1:0]      prev_q, prev_d;
  logic [15:0]     pos_q, pos_d;
  logic            dir_q, dir_d;
  logic [RW-1:0]   rev_q, rev_d;
  logic            rev_int_q, rev_int_d;
  logic            err_q, err_d;
  logic [WW-1:0]   win_q, win_d;
  logic [15:0]     ecnt_q, ecnt_d;
  logic [15:0]     ecnt_inc;
  logic [15:0]     speed_q, speed_d;
  logic            spin_q, spin_d;
  logic            speed_vld_q, speed_vld_d;
  logic            fwd, bwd;
  logic [1:0]      step;

  // Gray code 00,01,11,10 mapped onto 0..3 so a step is a modular difference.
  function automatic logic [1:0] g2i(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign raw  = {a_sync_q[1], b_sync_q[1]};
  assign step = g2i(filt_q) - g2i(prev_q);

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILT - 1)) filt_d[i] = raw[i];
        else                            fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      filt_q   <= '0;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      a_sync_q <= {a_sync_q[0], bus.a_in};
      b_sync_q <= {b_sync_q[0], bus.b_in};
      filt_q   <= filt_d;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    prev_d      = prev_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    rev_d       = rev_q;
    rev_int_d   = 1'b0;
    err_d       = err_q;
    win_d       = win_q;
    ecnt_d      = ecnt_q;
    speed_d     = speed_q;
    spin_d      = spin_q;
    speed_vld_d = 1'b0;
    fwd         = 1'b0;
    bwd         = 1'b0;

    unique case (state_q)
      // Hold off until the filters have settled on the pin levels present at
      // reset release, then adopt that state as the reference without counting.
      INIT: begin
        if (init_q == IW'(FILT + 2)) begin
          prev_d  = filt_q;
          state_d = RUN;
        end else begin
          init_d = init_q + IW'(1);
        end
      end
      RUN: begin
        prev_d = filt_q;
        case (step)
          2'd1:    fwd   = 1'b1;
          2'd3:    bwd   = 1'b1;
          2'd2:    err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase

    if (fwd) begin
      pos_d = pos_q + 16'd1;
      dir_d = 1'b1;
      if (rev_q == RW'(CPR - 1)) begin
        rev_d     = '0;
        rev_int_d = 1'b1;
      end else begin
        rev_d = rev_q + RW'(1);
      end
    end
    if (bwd) begin
      pos_d = pos_q - 16'd1;
      dir_d = 1'b0;
      if (rev_q == '0) begin
        rev_d     = RW'(CPR - 1);
        rev_int_d = 1'b1;
      end else begin
        rev_d = rev_q - RW'(1);
      end
    end

    // clr overrides position bookkeeping only; direction and speed still see the edge.
    if (bus.clr) begin
      pos_d     = '0;
      rev_d     = '0;
      err_d     = 1'b0;
      rev_int_d = 1'b0;
    end

    ecnt_inc = ((fwd || bwd) && ecnt_q != '1) ? ecnt_q + 16'd1 : ecnt_q;
    if (win_q == WW'(WIN - 1)) begin
      win_d       = '0;
      speed_d     = ecnt_inc;
      spin_d      = (ecnt_inc != '0);
      speed_vld_d = 1'b1;
      ecnt_d      = '0;
    end else begin
      win_d  = win_q + WW'(1);
      ecnt_d = ecnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= '0;
      prev_q      <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      rev_q       <= '0;
      rev_int_q   <= 1'b0;
      err_q       <= 1'b0;
      win_q       <= '0;
      ecnt_q      <= '0;
      speed_q     <= '0;
      spin_q      <= 1'b0;
      speed_vld_q <= 1'b0;
    end else begin
      init_q      <= init_d;
      prev_q      <= prev_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      rev_q       <= rev_d;
      rev_int_q   <= rev_int_d;
      err_q       <= err_d;
      win_q       <= win_d;
      ecnt_q      <= ecnt_d;
      speed_q     <= speed_d;
      spin_q      <= spin_d;
      speed_vld_q <= speed_vld_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.spin      = spin_q;
  assign bus.speed     = speed_q;
  assign bus.speed_vld = speed_vld_q;
  assign bus.rev_int   = rev_int_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (FILT=4, CPR=8, WIN=100): table of
// pin steps with a latency-checking scoreboard, plus hand-written corner cases.
module tb_quad_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rev_cnt = 0;
  bit   mon_en = 1'b0;
  logic [15:0] last_pos = '0;

  quad_decoder_if bus();

  quad_decoder #(.FILT(4), .CPR(8), .WIN(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0]  ab;
    logic [15:0] pos;
    logic        dir;
    logic        rint;
  } vec_t;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    logic        rint;
    int          t;
  } exp_t;

  vec_t tbl [18];
  exp_t sb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] nxt_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_ab(input logic [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pos"}, bus.pos, 0);
    chk({tag, " dir"}, bus.dir, 0);
    chk({tag, " spin"}, bus.spin, 0);
    chk({tag, " speed"}, bus.speed, 0);
    chk({tag, " speed_vld"}, bus.speed_vld, 0);
    chk({tag, " rev_int"}, bus.rev_int, 0);
    chk({tag, " err"}, bus.err, 0);
  endtask

  task automatic wait_vld(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.speed_vld) seen = 1'b1;
    end
    chk({tag, " speed_vld timeout"}, seen, 1);
  endtask

  // clr asserted exactly on the cycle the given edge would be counted.
  task automatic clr_edge(input string tag, input logic [1:0] ab, input logic exp_dir);
    drive_ab(ab);
    idle(6);
    bus.clr = 1'b1;
    idle(1);
    bus.clr = 1'b0;
    chk({tag, " pos"}, bus.pos, 0);
    chk({tag, " err"}, bus.err, 0);
    chk({tag, " rev_int"}, bus.rev_int, 0);
    chk({tag, " dir"}, bus.dir, exp_dir);
    idle(12);
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.pos != last_pos) begin
      if (sb_q.size() == 0) begin
        chk("unexpected pos change", bus.pos, last_pos);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb pos", bus.pos, e.pos);
        chk("sb dir", bus.dir, e.dir);
        chk("sb rev_int", bus.rev_int, e.rint);
        chk("sb latency", cyc - e.t, 7);
      end
    end
    if (mon_en && bus.rev_int) rev_cnt++;
    last_pos = bus.pos;
  end

  initial begin
    logic [1:0] ab;
    tbl[0]  = '{2'b01, 16'd1,      1'b1, 1'b0};
    tbl[1]  = '{2'b11, 16'd2,      1'b1, 1'b0};
    tbl[2]  = '{2'b10, 16'd3,      1'b1, 1'b0};
    tbl[3]  = '{2'b00, 16'd4,      1'b1, 1'b0};
    tbl[4]  = '{2'b10, 16'd3,      1'b0, 1'b0};
    tbl[5]  = '{2'b11, 16'd2,      1'b0, 1'b0};
    tbl[6]  = '{2'b01, 16'd1,      1'b0, 1'b0};
    tbl[7]  = '{2'b00, 16'd0,      1'b0, 1'b0};
    tbl[8]  = '{2'b10, 16'hFFFF,   1'b0, 1'b1};
    tbl[9]  = '{2'b00, 16'd0,      1'b1, 1'b1};
    tbl[10] = '{2'b01, 16'd1,      1'b1, 1'b0};
    tbl[11] = '{2'b11, 16'd2,      1'b1, 1'b0};
    tbl[12] = '{2'b10, 16'd3,      1'b1, 1'b0};
    tbl[13] = '{2'b00, 16'd4,      1'b1, 1'b0};
    tbl[14] = '{2'b01, 16'd5,      1'b1, 1'b0};
    tbl[15] = '{2'b11, 16'd6,      1'b1, 1'b0};
    tbl[16] = '{2'b10, 16'd7,      1'b1, 1'b0};
    tbl[17] = '{2'b00, 16'd8,      1'b1, 1'b1};

    rst_n = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    bus.clr  = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(10);
    chk("post-init pos", bus.pos, 0);
    chk("post-init err", bus.err, 0);

    mon_en = 1'b1;
    foreach (tbl[i]) begin
      drive_ab(tbl[i].ab);
      sb_q.push_back('{tbl[i].pos, tbl[i].dir, tbl[i].rint, cyc});
      idle(20);
    end

    // 3-cycle glitch on A must be swallowed by the filter.
    bus.a_in = 1'b1;
    idle(3);
    bus.a_in = 1'b0;
    idle(20);
    chk("glitch pos", bus.pos, 8);

    drive_ab(2'b11);
    idle(20);
    chk("illegal err", bus.err, 1);
    chk("illegal pos", bus.pos, 8);
    chk("illegal dir", bus.dir, 1);
    mon_en = 1'b0;
    chk("scoreboard drained", sb_q.size(), 0);
    chk("rev_int pulses", rev_cnt, 3);

    clr_edge("clr fwd", 2'b10, 1'b1);
    clr_edge("clr rev wrap", 2'b11, 1'b0);

    wait_vld("align");
    ab = 2'b11;
    for (int k = 0; k < 10; k++) begin
      ab = nxt_fwd(ab);
      drive_ab(ab);
      idle(8);
    end
    wait_vld("busy window");
    chk("speed busy", bus.speed, 10);
    chk("spin busy", bus.spin, 1);
    idle(1);
    chk("speed_vld one cycle", bus.speed_vld, 0);
    chk("pos after speed edges", bus.pos, 10);
    wait_vld("idle window");
    chk("speed idle", bus.speed, 0);
    chk("spin idle", bus.spin, 0);

    for (int k = 0; k < 5; k++) begin
      ab = nxt_rev(ab);
      drive_ab(ab);
      idle(10);
    end
    chk("pos before reset", bus.pos, 5);

    #2 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    drive_ab(2'b11);
    idle(3);
    rst_n = 1'b1;
    idle(12);
    chk("pins-11 reset err", bus.err, 0);
    chk("pins-11 reset pos", bus.pos, 0);
    drive_ab(2'b10);
    idle(10);
    chk("first edge pos", bus.pos, 1);
    chk("first edge dir", bus.dir, 1);
    chk("first edge err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
